opcode_sequencer: RTL
=====================

# opcode_sequencer

Host-side command scheduler for the gray-scale GPU core array. It assembles 16-bit opcodes from 4-bit host writes and buffers them in a small FIFO. Each opcode is issued to the core array with a single-cycle execute strobe, and for read-type opcodes the serial result bits are collected into a word that is handed back through a valid/ready port. It replaces the free-running "toggle execute every other edge" scheme with explicit sequencing and back-pressure.

## Interface
- OPCODE_WIDTH, 16, opcode width; must be a multiple of 4
- FIFO_DEPTH, 8, opcode FIFO entries; must be a power of 2, at least 2
- RESULT_WIDTH, 8, bits collected per read opcode
- TIMEOUT, 255, maximum WAIT cycles without `core_valid` (watchdog build only)

Ports:
- clk  in  1  single clock; all logic on its rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  synchronous soft clear
- wr_valid  in  1  host nibble valid
- wr_nibble  in  4  host nibble, most significant nibble first
- wr_ready  out  1  nibble accepted when `wr_valid & wr_ready`
- core_opcode  out  OPCODE_WIDTH  opcode presented to the core array
- core_execute  out  1  one-cycle issue strobe
- core_valid  in  1  core result bit valid
- core_bit  in  1  core result bit
- res_valid  out  1  result word available
- res_data  out  RESULT_WIDTH  result word, first received bit at MSB
- res_ready  in  1  host consumes the result
- busy  out  1  high when the FSM is not in IDLE or the FIFO is non-empty
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of buffered opcodes
- err  out  1  sticky timeout flag

## Operation
- Assembler:
  - 2-bit nibble counter; each accepted nibble shifts into the low end of the assembly register.
  - The 4th accepted nibble pushes `{reg, wr_nibble}` into the FIFO in the same cycle, and the counter wraps to 0.
- `wr_ready = (fifo_count != FIFO_DEPTH)`. The condition is conservative, so a push never overflows.
- FSM states: IDLE, ISSUE, WAIT, RESULT.
  - IDLE: if `fifo_count != 0`, pop the head into `core_opcode` and go to ISSUE.
  - ISSUE: `core_execute = 1` for exactly this cycle. If `core_opcode[OPCODE_WIDTH-1]` (RD flag) is 1, go to WAIT with the bit counter cleared. Otherwise go to IDLE.
  - WAIT: on each cycle with `core_valid = 1`, shift `core_bit` in LSB-side (`res_data <= {res_data[RESULT_WIDTH-2:0], core_bit}`) and increment the bit counter. The cycle capturing bit RESULT_WIDTH-1 moves to RESULT.
  - RESULT: `res_valid = 1`; `res_data` is held stable. On `res_ready`, go to IDLE.
- `core_opcode` holds its value until the next pop.
- `core_valid` is ignored outside WAIT.
- FIFO: simultaneous push and pop is legal, and `fifo_count` stays unchanged. Pointers wrap modulo FIFO_DEPTH.
- flush:
  - Clears the FIFO, nibble counter, bit counter and `res_valid`, and forces IDLE.
  - `core_opcode`, `res_data` and `err` keep their values.
  - flush overrides a same-cycle push, pop or result handshake.
- rst: every register returns to its reset value regardless of state, including mid-WAIT or mid-assembly.

## Timing
- Reset values:
  - `core_opcode = 0`, `core_execute = 0`, `res_valid = 0`, `res_data = 0`
  - `fifo_count = 0`, `busy = 0`, `err = 0`
  - `wr_ready = 1`
- Issue latency: last nibble accepted at edge N; the FIFO holds it after N; IDLE pops at N+1; `core_execute` is high during cycle N+1..N+2 (the ISSUE state). This gives 2 cycles from last nibble to strobe when idle.
- Back-to-back non-RD opcodes issue every 2 cycles (IDLE, ISSUE, IDLE, ...).
- Result: `res_valid` rises the cycle after the last bit is captured. It falls the cycle after the `res_valid & res_ready` handshake. The next pop can happen at the earliest one cycle after that.
- All outputs except `wr_ready` are registered. `wr_ready` is combinational from `fifo_count` only.

## Configuration
- `SEQ_TIMEOUT_EN` defined:
  - An 8-bit watchdog counts WAIT cycles with `core_valid = 0` and clears on each valid bit.
  - When the count reaches TIMEOUT, the FSM goes to IDLE, sets `err`, and produces no result word.
  - `err` is cleared only by `rst`.
- Not defined: no watchdog logic; WAIT lasts indefinitely; `err` is tied to 0.

## Test plan
- Reset, then nibbles 1,2,3,4 (RD=0) → `core_opcode = 16'h1234`, `core_execute` high for exactly 1 cycle, 2 cycles after the 4th nibble; `busy` returns to 0.
- Write 8 opcodes with the FSM stalled in WAIT → `fifo_count = 8`, `wr_ready = 0`, and extra nibbles are not accepted. After the result handshake, the 8 opcodes issue in FIFO order.
- RD opcode `16'h8001`, core returns bits 1,0,1,1,0,0,1,0 with idle gaps between them → `res_data = 8'hB2`, `res_valid` held until `res_ready`, no new issue before the handshake.
- Push on the same cycle as a pop with count 3 → `fifo_count` stays 3; the pointer wrap after 20 opcodes preserves order.
- Flush asserted mid-assembly (2 nibbles) and mid-WAIT → FSM in IDLE, `fifo_count = 0`; the next 4 nibbles form a clean opcode with no leftover nibbles.
- With `SEQ_TIMEOUT_EN`: RD opcode issued and no `core_valid` for 255 cycles → `err = 1`, FSM in IDLE, `res_valid` stays 0. Without the macro: `busy` stays 1 and `err` stays 0.

Source files
------------

// File: rtl/opcode_sequencer.sv
// ============================================================================
// Module   : opcode_sequencer
// Purpose  : Assembles host nibbles into opcodes, queues them, issues each with
//            an execute strobe and gathers serial results for read opcodes.
//            Optional watchdog build: define SEQ_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module opcode_sequencer #(
    parameter int OPCODE_WIDTH = 16,
    parameter int FIFO_DEPTH   = 8,
    parameter int RESULT_WIDTH = 8,
    parameter int TIMEOUT      = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          wr_valid,
    input  logic [3:0]                    wr_nibble,
    output logic                          wr_ready,
    output logic [OPCODE_WIDTH-1:0]       core_opcode,
    output logic                          core_execute,
    input  logic                          core_valid,
    input  logic                          core_bit,
    output logic                          res_valid,
    output logic [RESULT_WIDTH-1:0]       res_data,
    input  logic                          res_ready,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NIB_N = OPCODE_WIDTH / 4;
    localparam int NIB_W = (NIB_N > 1) ? $clog2(NIB_N) : 1;
    localparam int BIT_W = (RESULT_WIDTH > 1) ? $clog2(RESULT_WIDTH) : 1;
    localparam int ASM_W = OPCODE_WIDTH - 4;

    localparam logic [NIB_W-1:0] LAST_NIB = NIB_W'(NIB_N - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(RESULT_WIDTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_RESULT = 2'd3;

    logic [1:0]              state_q, state_d;
    logic [NIB_W-1:0]        nib_cnt_q, nib_cnt_d;
    logic [ASM_W-1:0]        asm_q, asm_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [OPCODE_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [OPCODE_WIDTH-1:0] core_opcode_q, core_opcode_d;
    logic                    core_execute_q, core_execute_d;
    logic                    res_valid_q, res_valid_d;
    logic [RESULT_WIDTH-1:0] res_data_q, res_data_d;
    logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic                    busy_q, busy_d;

    logic w_ready;
    logic w_accept;
    logic w_push;
    logic w_pop;
    logic w_bit;
    logic w_last;
    logic w_timeout;

    // wr_ready looks only at the count, so a push can never overflow even
    // when no pop happens in the same cycle.
    assign w_ready  = (count_q != FULL_CNT);
    assign w_accept = wr_valid && w_ready && !flush;
    assign w_push   = w_accept && (nib_cnt_q == LAST_NIB);
    assign w_pop    = (state_q == S_IDLE) && (count_q != '0) && !flush;
    assign w_bit    = (state_q == S_WAIT) && core_valid && !flush;
    assign w_last   = w_bit && (bit_cnt_q == LAST_BIT);

    // ------------------------------------------------------------------
    // Assembler and FIFO bookkeeping
    // ------------------------------------------------------------------
    always_comb begin
        nib_cnt_d = nib_cnt_q;
        asm_d     = asm_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (flush) begin
            nib_cnt_d = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
        end else begin
            if (w_accept) begin
                asm_d     = ASM_W'({asm_q, wr_nibble});
                nib_cnt_d = (nib_cnt_q == LAST_NIB) ? '0 : nib_cnt_q + NIB_W'(1);
            end
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_mem[wr_ptr_q] <= {asm_q, wr_nibble};
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (count_q != '0) begin
                        state_d = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state_d = core_opcode_q[OPCODE_WIDTH-1] ? S_WAIT : S_IDLE;
                end
                S_WAIT: begin
                    if (w_last) begin
                        state_d = S_RESULT;
                    end else if (w_timeout) begin
                        state_d = S_IDLE;
                    end
                end
                S_RESULT: begin
                    if (res_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs (next values of the registered outputs)
    // ------------------------------------------------------------------
    always_comb begin
        core_opcode_d  = w_pop ? fifo_mem[rd_ptr_q] : core_opcode_q;
        core_execute_d = w_pop;
        res_data_d     = w_bit ? RESULT_WIDTH'({res_data_q, core_bit}) : res_data_q;
        res_valid_d    = res_valid_q;
        bit_cnt_d      = bit_cnt_q;
        if (flush) begin
            res_valid_d = 1'b0;
            bit_cnt_d   = '0;
        end else begin
            if (w_last) begin
                res_valid_d = 1'b1;
            end else if ((state_q == S_RESULT) && res_ready) begin
                res_valid_d = 1'b0;
            end
            if (state_q == S_ISSUE) begin
                bit_cnt_d = '0;
            end else if (w_bit) begin
                bit_cnt_d = w_last ? '0 : bit_cnt_q + BIT_W'(1);
            end
        end
        busy_d = (state_d != S_IDLE) || (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            nib_cnt_q      <= '0;
            asm_q          <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            core_opcode_q  <= '0;
            core_execute_q <= 1'b0;
            res_valid_q    <= 1'b0;
            res_data_q     <= '0;
            bit_cnt_q      <= '0;
            busy_q         <= 1'b0;
        end else begin
            nib_cnt_q      <= nib_cnt_d;
            asm_q          <= asm_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            core_opcode_q  <= core_opcode_d;
            core_execute_q <= core_execute_d;
            res_valid_q    <= res_valid_d;
            res_data_q     <= res_data_d;
            bit_cnt_q      <= bit_cnt_d;
            busy_q         <= busy_d;
        end
    end

    // ------------------------------------------------------------------
    // Optional WAIT watchdog
    // ------------------------------------------------------------------
`ifdef SEQ_TIMEOUT_EN
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    logic [7:0] wd_q, wd_d;
    logic       err_q, err_d;

    // Fires on the TIMEOUT-th consecutive silent WAIT cycle.
    assign w_timeout = (state_q == S_WAIT) && !core_valid && !flush && (wd_q == WD_LAST);

    always_comb begin
        wd_d  = wd_q;
        err_d = err_q;
        if (flush || (state_q != S_WAIT) || core_valid || w_timeout) begin
            wd_d = '0;
        end else begin
            wd_d = wd_q + 8'd1;
        end
        if (w_timeout) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT != 0);
    assign w_timeout        = 1'b0;
    assign err              = 1'b0;
`endif

    assign wr_ready     = w_ready;
    assign core_opcode  = core_opcode_q;
    assign core_execute = core_execute_q;
    assign res_valid    = res_valid_q;
    assign res_data     = res_data_q;
    assign busy         = busy_q;
    assign fifo_count   = count_q;

endmodule

`default_nettype wire
